// File: rtl/spi_mstr_slv_top_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_mstr_slv_top_if : host-side bus of the SPI loopback block (busy with SPI_BUSY_STATUS_EN)
// Revision 1.0
// ============================================================================
interface spi_mstr_slv_top_if #(
  parameter int SPI_TRF_BIT = 8
);
  logic [1:0]             req;
  logic [7:0]             wait_duration;
  logic [SPI_TRF_BIT-1:0] din_master;
  logic [SPI_TRF_BIT-1:0] din_slave;
  logic [SPI_TRF_BIT-1:0] dout_master;
  logic [SPI_TRF_BIT-1:0] dout_slave;
  logic                   done_tx;
  logic                   done_rx;
`ifdef SPI_BUSY_STATUS_EN
  logic                   busy;

  modport master (
    output req, wait_duration, din_master, din_slave,
    input  dout_master, dout_slave, done_tx, done_rx, busy
  );
  modport slave (
    input  req, wait_duration, din_master, din_slave,
    output dout_master, dout_slave, done_tx, done_rx, busy
  );
`else
  modport master (
    output req, wait_duration, din_master, din_slave,
    input  dout_master, dout_slave, done_tx, done_rx
  );
  modport slave (
    input  req, wait_duration, din_master, din_slave,
    output dout_master, dout_slave, done_tx, done_rx
  );
`endif
endinterface
`default_nettype wire

// File: rtl/spi_mstr_slv_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_mstr_slv_top : sclk generator + SPI master + SPI slave wired back-to-back.
// Optional busy output enabled by SPI_BUSY_STATUS_EN.  Revision 1.0
// ============================================================================
module spi_mstr_slv_top #(
  parameter int MASTER_FREQ = 100_000_000,
  parameter int SLAVE_FREQ  = 1_800_000,
  parameter int SPI_MODE    = 1,
  parameter int SPI_TRF_BIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_mstr_slv_top_if.slave bus
);

  localparam int DIV   = MASTER_FREQ / SLAVE_FREQ;
  localparam int HDIV  = DIV / 2;
  localparam int CNT_W = $clog2(HDIV + 1);
  localparam int BIT_W = (SPI_TRF_BIT > 2) ? $clog2(SPI_TRF_BIT) : 1;
  localparam bit CPOL  = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA  = (SPI_MODE % 2) == 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_SHIFT = 2'd2,
    TX_DONE  = 2'd3
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } stx_state_e;

  // sclk generator
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;

  // SPI wires
  logic             cs_n_q;
  logic             cs_n_prev_q;
  logic             mosi_q;
  logic             miso_q;

  // master TX
  tx_state_e              tx_state_q;
  logic [1:0]             req_q;
  logic [7:0]             gap_q;
  logic [SPI_TRF_BIT-1:0] tx_sr_q;
  logic [BIT_W-1:0]       tx_cnt_q;
  logic                   done_tx_q;

  // master RX
  rx_state_e              mrx_state_q;
  logic [SPI_TRF_BIT-1:0] mrx_sr_q;
  logic [BIT_W-1:0]       mrx_cnt_q;
  logic [SPI_TRF_BIT-1:0] dout_master_q;
  logic                   done_rx_q;

  // slave TX / RX
  stx_state_e             stx_state_q;
  logic [SPI_TRF_BIT-1:0] stx_sr_q;
  rx_state_e              srx_state_q;
  logic [SPI_TRF_BIT-1:0] srx_sr_q;
  logic [BIT_W-1:0]       srx_cnt_q;
  logic [SPI_TRF_BIT-1:0] dout_slave_q;

  logic lead, trail, launch, sample, cs_fall, tx_start;

  assign lead     = CPOL ? neg_q : pos_q;
  assign trail    = CPOL ? pos_q : neg_q;
  assign launch   = CPHA ? lead  : trail;
  assign sample   = CPHA ? trail : lead;
  assign cs_fall  = cs_n_prev_q & ~cs_n_q;
  assign tx_start = (gap_q == 8'd0) && (bus.req != 2'b00);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    pos_d  = 1'b0;
    neg_d  = 1'b0;
    if (cs_n_q) begin
      cnt_d  = '0;
      sclk_d = CPOL;
    end else if (cnt_q == CNT_W'(HDIV - 1)) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
      pos_d  = ~sclk_q;
      neg_d  = sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      sclk_q      <= CPOL;
      pos_q       <= 1'b0;
      neg_q       <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      sclk_q      <= sclk_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      cs_n_prev_q <= cs_n_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      req_q      <= 2'b00;
      gap_q      <= 8'd0;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      done_tx_q  <= 1'b0;
    end else begin
      done_tx_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (gap_q != 8'd0) begin
            gap_q <= gap_q - 8'd1;
          end else if (tx_start) begin
            req_q      <= bus.req;
            tx_cnt_q   <= '0;
            cs_n_q     <= 1'b0;
            tx_state_q <= TX_SETUP;
            // Without CPHA the first bit must be on the wire before the first edge
            if (CPHA) begin
              tx_sr_q <= bus.din_master;
            end else begin
              mosi_q  <= bus.din_master[SPI_TRF_BIT-1];
              tx_sr_q <= {bus.din_master[SPI_TRF_BIT-2:0], 1'b0};
            end
          end
        end
        TX_SETUP: begin
          if (!CPHA) begin
            tx_state_q <= TX_SHIFT;
          end else if (launch) begin
            mosi_q     <= tx_sr_q[SPI_TRF_BIT-1];
            tx_sr_q    <= {tx_sr_q[SPI_TRF_BIT-2:0], 1'b0};
            tx_state_q <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (launch) begin
            mosi_q  <= tx_sr_q[SPI_TRF_BIT-1];
            tx_sr_q <= {tx_sr_q[SPI_TRF_BIT-2:0], 1'b0};
          end
          if (sample) begin
            if (tx_cnt_q == BIT_W'(SPI_TRF_BIT - 1)) begin
              cs_n_q     <= 1'b1;
              done_tx_q  <= req_q[0];
              tx_state_q <= TX_DONE;
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
          end
        end
        TX_DONE: begin
          gap_q      <= (bus.wait_duration == 8'd0) ? 8'd1 : bus.wait_duration;
          tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mrx_state_q   <= RX_IDLE;
      mrx_sr_q      <= '0;
      mrx_cnt_q     <= '0;
      dout_master_q <= '0;
      done_rx_q     <= 1'b0;
    end else begin
      done_rx_q <= 1'b0;
      case (mrx_state_q)
        RX_IDLE: begin
          if (tx_state_q == TX_SETUP && req_q[1]) begin
            mrx_cnt_q   <= '0;
            mrx_state_q <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (sample) begin
            mrx_sr_q <= {mrx_sr_q[SPI_TRF_BIT-2:0], miso_q};
            if (mrx_cnt_q == BIT_W'(SPI_TRF_BIT - 1)) begin
              dout_master_q <= {mrx_sr_q[SPI_TRF_BIT-2:0], miso_q};
              done_rx_q     <= 1'b1;
              mrx_state_q   <= RX_IDLE;
            end else begin
              mrx_cnt_q <= mrx_cnt_q + 1'b1;
            end
          end
        end
        default: mrx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stx_state_q <= ST_IDLE;
      stx_sr_q    <= '0;
      miso_q      <= 1'b0;
    end else begin
      case (stx_state_q)
        ST_IDLE: begin
          if (cs_fall && req_q[1]) begin
            stx_state_q <= ST_SEND;
            if (CPHA) begin
              stx_sr_q <= bus.din_slave;
            end else begin
              miso_q   <= bus.din_slave[SPI_TRF_BIT-1];
              stx_sr_q <= {bus.din_slave[SPI_TRF_BIT-2:0], 1'b0};
            end
          end
        end
        ST_SEND: begin
          if (cs_n_q) begin
            stx_state_q <= ST_IDLE;
          end else if (launch) begin
            miso_q   <= stx_sr_q[SPI_TRF_BIT-1];
            stx_sr_q <= {stx_sr_q[SPI_TRF_BIT-2:0], 1'b0};
          end
        end
        default: stx_state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srx_state_q  <= RX_IDLE;
      srx_sr_q     <= '0;
      srx_cnt_q    <= '0;
      dout_slave_q <= '0;
    end else begin
      case (srx_state_q)
        RX_IDLE: begin
          if (cs_fall && req_q[0]) begin
            srx_cnt_q   <= '0;
            srx_state_q <= RX_RECV;
          end
        end
        RX_RECV: begin
          // Final bit lands on the same edge the master enters DONE
          if (cs_n_q) begin
            srx_state_q <= RX_IDLE;
          end else if (sample) begin
            srx_sr_q <= {srx_sr_q[SPI_TRF_BIT-2:0], mosi_q};
            if (srx_cnt_q == BIT_W'(SPI_TRF_BIT - 1)) begin
              dout_slave_q <= {srx_sr_q[SPI_TRF_BIT-2:0], mosi_q};
              srx_state_q  <= RX_IDLE;
            end else begin
              srx_cnt_q <= srx_cnt_q + 1'b1;
            end
          end
        end
        default: srx_state_q <= RX_IDLE;
      endcase
    end
  end

`ifdef SPI_BUSY_STATUS_EN
  logic busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
    end else if (tx_state_q == TX_IDLE) begin
      busy_q <= tx_start;
    end else begin
      busy_q <= (tx_state_q != TX_DONE);
    end
  end

  assign bus.busy = busy_q;
`endif

  assign bus.dout_master = dout_master_q;
  assign bus.dout_slave  = dout_slave_q;
  assign bus.done_tx     = done_tx_q;
  assign bus.done_rx     = done_rx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mstr_slv_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_mstr_slv_top : directed bench for the SPI loopback block (mode 1, 8 bit).
// Revision 1.0
// ============================================================================
module tb_spi_mstr_slv_top;

  logic clk = 1'b1;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n_tx, n_rx, n_fall, n_same, n_done, gap;
  logic timed_out;
  logic cs_ok, sclk_ok;
  logic [7:0] rec_s, rec_m;

  spi_mstr_slv_top_if #(.SPI_TRF_BIT(8)) bus ();

  spi_mstr_slv_top #(
    .MASTER_FREQ(100_000_000),
    .SLAVE_FREQ (1_800_000),
    .SPI_MODE   (1),
    .SPI_TRF_BIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer; req drops in the first done cycle so no second transfer starts
  task automatic xfer(input logic [1:0] r, input logic [7:0] dm, input logic [7:0] ds);
    logic prev_sclk;
    bit   seen;
    n_tx = 0; n_rx = 0; n_fall = 0; n_same = 0;
    timed_out = 1'b1;
    seen = 1'b0;
    bus.req = r;
    bus.din_master = dm;
    bus.din_slave = ds;
    prev_sclk = dut.sclk_q;
    for (int c = 0; c < 1500 && !seen; c++) begin
      @(posedge clk); #1;
      if (prev_sclk && !dut.sclk_q) n_fall++;
      prev_sclk = dut.sclk_q;
      if (bus.done_tx) n_tx++;
      if (bus.done_rx) n_rx++;
      if (bus.done_tx || bus.done_rx) begin
        seen = 1'b1;
        timed_out = 1'b0;
        bus.req = 2'b00;
        if (bus.done_tx && bus.done_rx) n_same++;
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done_tx) n_tx++;
      if (bus.done_rx) n_rx++;
    end
  endtask

  task automatic wait_done(output logic to);
    to = 1'b1;
    for (int c = 0; c < 1500 && to; c++) begin
      @(posedge clk); #1;
      if (bus.done_tx || bus.done_rx) to = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.req = 2'b00;
    bus.wait_duration = 8'd4;
    bus.din_master = 8'h00;
    bus.din_slave = 8'h00;
    #15 rst = 1'b1;

    // idle after reset
    cs_ok = 1'b1; sclk_ok = 1'b1; n_done = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (dut.cs_n_q !== 1'b1) cs_ok = 1'b0;
      if (dut.sclk_q !== 1'b0) sclk_ok = 1'b0;
      if (bus.done_tx || bus.done_rx) n_done++;
    end
    check("idle_cs_n_high", cs_ok, 1);
    check("idle_sclk_low", sclk_ok, 1);
    check("idle_no_done", n_done, 0);
    check("rst_dout_master", bus.dout_master, 8'h00);
    check("rst_dout_slave", bus.dout_slave, 8'h00);

    // master -> slave
    xfer(2'b01, 8'hA5, 8'hFF);
    check("mosi_timeout", timed_out, 0);
    check("mosi_done_tx", n_tx, 1);
    check("mosi_done_rx", n_rx, 0);
    check("mosi_sclk_falls", n_fall, 8);
    check("mosi_dout_slave", bus.dout_slave, 8'hA5);
    check("mosi_dout_master", bus.dout_master, 8'h00);

    // slave -> master
    xfer(2'b10, 8'h11, 8'h3C);
    check("miso_timeout", timed_out, 0);
    check("miso_done_tx", n_tx, 0);
    check("miso_done_rx", n_rx, 1);
    check("miso_dout_master", bus.dout_master, 8'h3C);
    check("miso_dout_slave", bus.dout_slave, 8'hA5);

    // full duplex
    xfer(2'b11, 8'h5A, 8'hC3);
    check("fdx_timeout", timed_out, 0);
    check("fdx_same_clk", n_same, 1);
    check("fdx_done_tx", n_tx, 1);
    check("fdx_done_rx", n_rx, 1);
    check("fdx_dout_slave", bus.dout_slave, 8'h5A);
    check("fdx_dout_master", bus.dout_master, 8'h3C ^ 8'h3C ^ 8'hC3);

    // back-to-back with a 10-cycle gap; new data presented during the gap
    repeat (20) @(posedge clk);
    #1;
    bus.wait_duration = 8'd10;
    bus.din_master = 8'h81;
    bus.din_slave = 8'h42;
    bus.req = 2'b11;
    wait_done(timed_out);
    check("b2b_first_timeout", timed_out, 0);
    rec_s = bus.dout_slave;
    rec_m = bus.dout_master;
    check("b2b_first_slave", rec_s, 8'h81);
    check("b2b_first_master", rec_m, 8'h42);
    bus.din_master = 8'h7E;
    bus.din_slave = 8'h24;
    gap = 0;
    for (int c = 0; c < 200 && dut.cs_n_q; c++) begin
      gap++;
      @(posedge clk); #1;
    end
    check("b2b_gap_ge_10", (gap >= 10), 1);
    wait_done(timed_out);
    bus.req = 2'b00;
    check("b2b_second_timeout", timed_out, 0);
    check("b2b_second_slave", bus.dout_slave, 8'h7E);
    check("b2b_second_master", bus.dout_master, 8'h24);
    repeat (40) @(posedge clk);

    // reset after the fourth sampled bit
    #1;
    bus.wait_duration = 8'd4;
    bus.din_master = 8'hF0;
    bus.din_slave = 8'h0F;
    bus.req = 2'b11;
    n_fall = 0; n_done = 0;
    begin
      logic prev_sclk;
      prev_sclk = dut.sclk_q;
      for (int c = 0; c < 1000 && n_fall < 4; c++) begin
        @(posedge clk); #1;
        if (prev_sclk && !dut.sclk_q) n_fall++;
        prev_sclk = dut.sclk_q;
        if (bus.done_tx || bus.done_rx) n_done++;
      end
    end
    check("midrst_reached_bit4", n_fall, 4);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_no_done", n_done + int'(bus.done_tx) + int'(bus.done_rx), 0);
    check("midrst_cs_n", dut.cs_n_q, 1);
    check("midrst_dout_slave", bus.dout_slave, 8'h00);
    check("midrst_dout_master", bus.dout_master, 8'h00);
    bus.req = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    xfer(2'b11, 8'h96, 8'h69);
    check("post_timeout", timed_out, 0);
    check("post_done_tx", n_tx, 1);
    check("post_done_rx", n_rx, 1);
    check("post_dout_slave", bus.dout_slave, 8'h96);
    check("post_dout_master", bus.dout_master, 8'h69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
